// File: rtl/mantissa_divider.sv
// mantissa_divider: iterative restoring divider for normalized floating-point
// significands. It resolves one quotient bit per clock over WIDTH+1 steps.
// A final NORM cycle then registers a one-position-normalized, truncated
// quotient, an exponent-adjust flag, a sticky bit and a divide-by-zero flag.
module mantissa_divider #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             exp_adj,
  output logic             sticky,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_NORM
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]    r_cnt;       // remaining restoring steps minus one
  logic [WIDTH-1:0] r_b;         // latched divisor
  logic [WIDTH:0]   r_rem;       // partial remainder, one guard bit wide
  logic [WIDTH:0]   r_quo;       // raw quotient Q = floor((a << WIDTH) / b)
  logic             r_dbz;       // divisor was zero at acceptance

  logic [WIDTH+1:0] w_trial;     // remainder minus divisor, with sign bit
  logic             w_ge;        // trial subtraction did not go negative
  logic [WIDTH:0]   w_rem_sel;
  logic [WIDTH:0]   w_rem_shift;
  logic [WIDTH:0]   w_quo_shift;

  // One restoring step: subtract, keep the difference only if non-negative,
  // and shift the decision into the quotient.
  always_comb begin
    w_trial     = {1'b0, r_rem} - {2'b00, r_b};
    w_ge        = ~w_trial[WIDTH+1];
    w_rem_sel   = w_ge ? w_trial[WIDTH:0] : r_rem;
    w_rem_shift = {w_rem_sel[WIDTH-1:0], 1'b0};
    w_quo_shift = {r_quo[WIDTH-1:0], w_ge};
  end

  assign busy = (r_state != S_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE -> CALC on start, CALC -> NORM after the last
  // step, NORM always returns to IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_CALC;
      S_CALC:  if (r_cnt == '0) w_state_next = S_NORM;
      S_NORM:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered results. These cover operand latch, iteration
  // and normalization. start outside IDLE is ignored, so a request made
  // mid-operation cannot corrupt the operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_b         <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dbz       <= 1'b0;
      done        <= 1'b0;
      q           <= '0;
      exp_adj     <= 1'b0;
      sticky      <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_b   <= b;
            r_rem <= {1'b0, a};
            r_quo <= '0;
            r_cnt <= CW'(WIDTH);
            r_dbz <= (b == '0);
          end
        end
        S_CALC: begin
          r_rem <= w_rem_shift;
          r_quo <= w_quo_shift;
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        S_NORM: begin
          done        <= 1'b1;
          div_by_zero <= r_dbz;
          if (r_dbz) begin
            // A zero divisor still took the full latency; the result saturates.
            q       <= '1;
            exp_adj <= 1'b0;
            sticky  <= 1'b0;
          end else if (r_quo[WIDTH]) begin
            q       <= r_quo[WIDTH:1];
            exp_adj <= 1'b0;
            sticky  <= r_quo[0] | (r_rem != '0);
          end else begin
            q       <= r_quo[WIDTH-1:0];
            exp_adj <= 1'b1;
            sticky  <= (r_rem != '0);
          end
        end
        default: begin
          done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mantissa_divider.sv
// Directed testbench for mantissa_divider. Its expected values are worked out
// by hand from Q = floor((a << 24) / b), with one-position normalization.
module tb_mantissa_divider;

  localparam int W = 24;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic         exp_adj;
  logic         sticky;
  logic         div_by_zero;

  int total = 0;
  int bad   = 0;

  mantissa_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .exp_adj     (exp_adj),
    .sticky      (sticky),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request; the next rising edge accepts it. Call at a negedge.
  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
  endtask

  // Wait for done after an issue(). lat counts rising edges after the
  // acceptance edge. If inject is set, a stray start with different operands
  // is pulsed 5 cycles into the operation.
  task automatic finish(input string tag, input bit inject,
                        input logic [W-1:0] eq, input logic ea,
                        input logic es, input logic ez);
    int lat;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (inject && lat == 5) begin
        a = 24'h800000;
        b = 24'hC00000;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'd26);
    chk({tag, "_q"}, 32'(q), 32'(eq));
    chk({tag, "_flags"}, {29'd0, exp_adj, sticky, div_by_zero}, {29'd0, ea, es, ez});
    $display("op %s: a=%06h b=%06h q=%06h exp_adj=%0d sticky=%0d dbz=%0d lat=%0d",
             tag, a, b, q, exp_adj, sticky, div_by_zero, lat);
  endtask

  initial begin
    int seen;

    // Reset state.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_outs", {26'd0, done, exp_adj, sticky, div_by_zero, 2'b00}, 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(24'h800000, 24'h800000); finish("equal", 0, 24'h800000, 0, 0, 0);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    issue(24'hC00000, 24'h800000); finish("above1", 0, 24'hC00000, 0, 0, 0);
    @(negedge clk);
    issue(24'h800000, 24'hC00000); finish("below1", 0, 24'hAAAAAA, 1, 1, 0);
    @(negedge clk);
    issue(24'hFFFFFF, 24'h800000); finish("maxsig", 0, 24'hFFFFFF, 0, 0, 0);
    @(negedge clk);
    issue(24'h900000, 24'h000000); finish("dbz", 0, 24'hFFFFFF, 0, 0, 1);
    @(negedge clk);
    issue(24'h000000, 24'h800000); finish("zero_a", 0, 24'h000000, 1, 0, 0);
    @(negedge clk);

    // A start during CALC is ignored; the result belongs to the first operands.
    issue(24'hC00000, 24'h800000); finish("ignore", 1, 24'hC00000, 0, 0, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) seen = 1;
    end
    chk("ignore_no_second", 32'(seen), 32'd0);

    // A start in the done cycle is accepted straight away.
    issue(24'hFFFFFF, 24'h800000); finish("b2b_first", 0, 24'hFFFFFF, 0, 0, 0);
    issue(24'h800000, 24'hC00000); finish("b2b_second", 0, 24'hAAAAAA, 1, 1, 0);
    @(negedge clk);

    // Asynchronous reset 10 cycles into CALC clears everything, and the
    // operation produces no done pulse.
    issue(24'hC00000, 24'h800000);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_q", 32'(q), 32'd0);
    chk("midrst_outs", {28'd0, done, exp_adj, sticky, div_by_zero}, 32'd0);
    $display("op midrst: busy=%0d done=%0d q=%06h", busy, done, q);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);

    // Recovery after reset.
    issue(24'h800000, 24'h800000); finish("after_rst", 0, 24'h800000, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
